// File: rtl/uop_queue_if.sv
// uop_queue_if: handshake bundle between decode, the uop queue and issue.
//   master modport : the decode/issue side. It drives in_valid, in_uop,
//                    in_nop, in_invalid and out_ready, and observes the rest.
//   slave modport  : the queue itself.
//   in_*           : decode -> queue push channel with nop/invalid qualifiers.
//   out_*          : queue -> issue head-of-queue channel.
//   count, illegal : occupancy and sticky illegal-instruction status.
interface uop_queue_if #(
  parameter int UOP_WIDTH = 60,
  parameter int CNT_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [UOP_WIDTH-1:0] in_uop;
  logic                 in_nop;
  logic                 in_invalid;
  logic                 out_valid;
  logic                 out_ready;
  logic [UOP_WIDTH-1:0] out_uop;
  logic [CNT_WIDTH-1:0] count;
  logic                 illegal;

  modport master (
    output in_valid, in_uop, in_nop, in_invalid, out_ready,
    input  in_ready, out_valid, out_uop, count, illegal
  );

  modport slave (
    input  in_valid, in_uop, in_nop, in_invalid, out_ready,
    output in_ready, out_valid, out_uop, count, illegal
  );
endinterface

// File: rtl/uop_queue.sv
// uop_queue: in-order micro-op FIFO between decode and issue.
//   Nops are accepted and dropped. An invalid opcode is accepted but not
//   stored; it sets a sticky illegal flag that blocks further input until
//   flush or reset. Entries that were already queued still drain.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   flush : synchronous clear of pointers, count and illegal. It overrides
//           any push or pop in the same cycle.
//   q     : uop_queue_if slave (push channel, pop channel, count, illegal)
module uop_queue #(
  parameter int UOP_WIDTH = 60,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  uop_queue_if.slave q
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [UOP_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;
  logic [CNT_WIDTH-1:0] count;
  logic                 illegal;

  logic push_fire;
  logic pop_fire;
  logic store;

  // Ready depends only on registered state. This keeps a full queue from
  // writing through, even when issue pops in the same cycle.
  assign q.in_ready  = (count != CNT_WIDTH'(DEPTH)) && !illegal;
  assign q.out_valid = (count != '0);
  assign q.out_uop   = q.out_valid ? mem[head] : '0;
  assign q.count     = count;
  assign q.illegal   = illegal;

  assign push_fire = q.in_valid && q.in_ready;
  assign pop_fire  = q.out_valid && q.out_ready;
  // Invalid takes precedence over nop. Neither one occupies an entry.
  assign store     = push_fire && !q.in_invalid && !q.in_nop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      if (push_fire && q.in_invalid)
        illegal <= 1'b1;
      if (store)
        tail <= tail + PTR_WIDTH'(1);
      if (pop_fire)
        head <= head + PTR_WIDTH'(1);
      case ({store, pop_fire})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset. Stale contents are never visible, because
  // out_uop is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (store && !rst && !flush)
      mem[tail] <= q.in_uop;
  end
endmodule

// File: tb/tb_uop_queue.sv
module tb_uop_queue;
  localparam int UW = 60;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  // Reference state, kept by the stimulus process.
  logic [UW-1:0] exp_q [$];
  int            mcnt;
  logic          mill;

  uop_queue_if #(.UOP_WIDTH(UW), .CNT_WIDTH(CW)) q ();

  uop_queue #(.UOP_WIDTH(UW), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the head uop whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst && !flush && q.out_valid === 1'b1) begin
      if (exp_q.size() == 0)
        chk("unexpected_out_valid", 64'(q.out_valid), 64'd0);
      else if (q.out_ready)
        chk("pop_uop", 64'(q.out_uop), 64'(exp_q.pop_front()));
      else
        chk("hold_uop", 64'(q.out_uop), 64'(exp_q[0]));
    end
  end

  // One clock cycle. The task is entered just after a rising edge and
  // returns just after the next rising edge.
  task automatic cycle(input logic v, input logic [UW-1:0] u, input logic nop,
                       input logic inv, input logic ordy, input logic fl);
    logic rdy;
    logic pop;
    q.in_valid   = v;
    q.in_uop     = u;
    q.in_nop     = nop;
    q.in_invalid = inv;
    q.out_ready  = ordy;
    flush        = fl;
    @(negedge clk);
    rdy = (mcnt != 8) && !mill;
    chk("count", 64'(q.count), 64'(mcnt));
    chk("in_ready", 64'(q.in_ready), 64'(rdy));
    chk("out_valid", 64'(q.out_valid), 64'(mcnt != 0));
    chk("illegal", 64'(q.illegal), 64'(mill));
    if (mcnt == 0) chk("empty_out_uop", 64'(q.out_uop), 64'd0);
    if (fl) begin
      mcnt = 0;
      mill = 1'b0;
      exp_q.delete();
    end else begin
      pop = (mcnt != 0) && ordy;
      if (v && rdy && inv) mill = 1'b1;
      if (v && rdy && !inv && !nop) begin
        exp_q.push_back(u);
        mcnt++;
      end
      if (pop) mcnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [UW-1:0] u);
    cycle(1'b1, u, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    q.in_valid = 1'b0; q.in_uop = '0; q.in_nop = 1'b0;
    q.in_invalid = 1'b0; q.out_ready = 1'b0;
    mcnt = 0; mill = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", 64'(q.count), 64'd0);
    chk("rst_in_ready", 64'(q.in_ready), 64'd1);
    chk("rst_out_valid", 64'(q.out_valid), 64'd0);
    chk("rst_out_uop", 64'(q.out_uop), 64'd0);
    chk("rst_illegal", 64'(q.illegal), 64'd0);
    @(posedge clk); #1;

    // Push A, B, C, then drain them in order.
    push(60'hA); push(60'hB); push(60'hC);
    chk("abc_count", 64'(q.count), 64'd3);
    chk("abc_head", 64'(q.out_uop), 64'hA);
    repeat (3) idle(1'b1);
    idle(1'b0);

    // Fill to 8, a 9th push is held off, pop one, then stream across the wrap.
    for (int i = 0; i < 8; i++) push(60'h100 + 60'(i));
    chk("full_count", 64'(q.count), 64'd8);
    chk("full_in_ready", 64'(q.in_ready), 64'd0);
    push(60'h1FF);
    chk("ninth_count", 64'(q.count), 64'd8);
    idle(1'b1);
    chk("after_pop_in_ready", 64'(q.in_ready), 64'd1);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 60'h200 + 60'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("stream_count", 64'(q.count), 64'd7);
    repeat (8) idle(1'b1);

    // Nops interleaved with real uops are dropped.
    cycle(1'b1, 60'hA1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 60'hE1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 60'hB1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 60'hE2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("nop_count", 64'(q.count), 64'd0);
    idle(1'b1);

    // An invalid uop sets the sticky illegal flag, and the queue still drains.
    push(60'h31); push(60'h32);
    cycle(1'b1, 60'h3F, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ill_flag", 64'(q.illegal), 64'd1);
    chk("ill_in_ready", 64'(q.in_ready), 64'd0);
    chk("ill_count", 64'(q.count), 64'd2);
    push(60'h33);
    repeat (2) idle(1'b1);
    idle(1'b0);
    chk("ill_sticky", 64'(q.illegal), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_illegal", 64'(q.illegal), 64'd0);
    chk("flush_in_ready", 64'(q.in_ready), 64'd1);
    idle(1'b0);

    // Flush overrides a simultaneous push and pop.
    for (int i = 0; i < 5; i++) push(60'h40 + 60'(i));
    cycle(1'b1, 60'h4F, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_count", 64'(q.count), 64'd0);
    chk("flush_out_valid", 64'(q.out_valid), 64'd0);
    idle(1'b1);

    // A full queue with pop and push in the same cycle only pops.
    for (int i = 0; i < 8; i++) push(60'h500 + 60'(i));
    cycle(1'b1, 60'h5FF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pop_count", 64'(q.count), 64'd7);
    repeat (7) idle(1'b1);
    idle(1'b0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
